// File: rtl/i2c_target_regs.sv
// I2C target exposing an 8-bit register pointer to fabric: writes come out as
// one-clk pulses, reads pull a byte from rd_data for the current pointer.
module i2c_target_regs #(
  parameter logic [6:0] DEVICE_ADDR = 7'h48,
  parameter int         FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  logic          r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
  logic [CW-1:0] r_scl_cnt, r_sda_cnt;
  logic          r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;

  state_t        r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_ptr;
  logic          r_rw;
  logic          r_sda_oe;
  logic          r_busy;
  logic          r_wr_valid;
  logic [7:0]    r_wr_addr;
  logic [7:0]    r_wr_data;

  logic          w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]    w_byte;
  logic          w_match;

  // Synchronisers and filters come out of reset at the idle bus level (both high)
  // so that releasing reset never fabricates a START or STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_s1  <= 1'b1;
      r_scl_s2  <= 1'b1;
      r_sda_s1  <= 1'b1;
      r_sda_s2  <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_fd  <= 1'b1;
      r_sda_fd  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value.
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;

      if (r_scl_s2 == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == CW'(FILTER_LEN - 1)) begin
        r_scl_f   <= r_scl_s2;
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + CW'(1);
      end

      if (r_sda_s2 == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == CW'(FILTER_LEN - 1)) begin
        r_sda_f   <= r_sda_s2;
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + CW'(1);
      end

      r_scl_fd <= r_scl_f;
      r_sda_fd <= r_sda_f;
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_fd;
  assign w_scl_fall = ~r_scl_f & r_scl_fd;
  assign w_start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
  assign w_byte     = {r_shift[6:0], r_sda_f};
  assign w_match    = (w_byte[7:1] == DEVICE_ADDR) && (DEVICE_ADDR != 7'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_valid <= 1'b0;

      if (w_stop) begin
        r_state   <= S_IDLE;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= '0;
        r_busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_scl_rise) begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              case (r_state)
                S_ADDR: begin
                  if (w_match) begin
                    r_state <= S_ADDR_ACK;
                    r_busy  <= 1'b1;
                    r_rw    <= r_sda_f;
                  end else begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                  end
                end
                S_PTR: begin
                  r_ptr   <= w_byte;
                  r_state <= S_PTR_ACK;
                end
                default: begin
                  r_wr_valid <= 1'b1;
                  r_wr_addr  <= r_ptr;
                  r_wr_data  <= w_byte;
                  r_state    <= S_WDATA_ACK;
                end
              endcase
            end
          end
          S_RDATA: r_bit_cnt <= r_bit_cnt + 4'd1;
          S_RDATA_ACK: begin
            // Every byte handed to the master advances the pointer, NACKed or not.
            r_ptr <= r_ptr + 8'd1;
            if (r_sda_f) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (w_scl_fall) begin
        case (r_state)
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            // First falling edge pulls the ACK low, the second one ends the ACK slot.
            if (!r_sda_oe) begin
              r_sda_oe <= 1'b1;
            end else begin
              r_bit_cnt <= '0;
              r_sda_oe  <= 1'b0;
              case (r_state)
                S_ADDR_ACK: begin
                  if (r_rw) begin
                    r_shift  <= rd_data;
                    r_sda_oe <= ~rd_data[7];
                    r_state  <= S_RDATA;
                  end else begin
                    r_state <= S_PTR;
                  end
                end
                S_PTR_ACK: r_state <= S_WDATA;
                default: begin
                  r_ptr   <= r_ptr + 8'd1;
                  r_state <= S_WDATA;
                end
              endcase
            end
          end
          S_RDATA: begin
            if (r_bit_cnt == 4'd8) begin
              r_sda_oe <= 1'b0;
              r_state  <= S_RDATA_ACK;
            end else begin
              r_sda_oe <= ~r_shift[6];
              r_shift  <= r_shift << 1;
            end
          end
          S_RDATA_ACK: begin
            r_shift   <= rd_data;
            r_sda_oe  <= ~rd_data[7];
            r_bit_cnt <= '0;
            r_state   <= S_RDATA;
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign rd_addr  = r_ptr;
  assign busy     = r_busy;

endmodule
